xor_rr_scheduler: RTL and testbench
===================================

Name: xor_rr_scheduler

Overview:
Shares one registered WIDTH-bit XOR datapath between N_REQ requesters using round-robin arbitration.
Each requester offers an operand pair with valid/ready. The winner's a^b is registered into a single output slot, tagged with the requester ID, and held until the consumer accepts it.
The block sits between the per-channel operand sources and the shared XOR unit. It is the only path by which requesters reach that unit.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
N_REQ, 4, number of requesters (2..16)
ID_W, 2, requester ID width; must equal clog2(N_REQ)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  in  N_REQ  bit i = requester i presents operands
req_a  in  N_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B; same packing
req_ready  out  N_REQ  one-hot (or zero) accept strobe; transfer when req_valid[i] && req_ready[i]
rsp_valid  out  1  result slot occupied
rsp_data  out  WIDTH  registered a^b of accepted request
rsp_id  out  ID_W  index of requester that produced rsp_data
rsp_ready  in  1  consumer accepts result when rsp_valid && rsp_ready
busy  out  1  equals rsp_valid
ops_count  out  16  number of accepted requests since reset, saturating at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at an edge) forces the following, regardless of any other input, including mid-transaction:
  - rsp_valid=0, rsp_data=0, rsp_id=0, ops_count=0, rr pointer ptr=0, state EMPTY.
  - An in-flight result is discarded.
  - req_ready is forced to 0 combinationally while rst_n=0.
- FSM has two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- slot_free = EMPTY, or FULL && rsp_ready (drain and refill in the same cycle).
- Arbitration is combinational:
  - When slot_free and any req_valid, the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
  - req_ready = one-hot(winner); otherwise req_ready=0.
  - req_ready may depend combinationally on req_valid and rsp_ready; no combinational path from req_a/req_b to any output.
- On an edge with an accept:
  - rsp_data <= a_w ^ b_w, rsp_id <= winner, rsp_valid <= 1.
  - ptr <= (winner+1) mod N_REQ.
  - ops_count <= ops_count+1, unless already 16'hFFFF.
- On an edge with slot_free and no req_valid: rsp_valid <= 0. ptr, rsp_data and rsp_id hold their values.
- FULL && !rsp_ready: rsp_data and rsp_id hold stable, req_ready=0, ptr holds.
- Latency is 1 cycle from accept edge to rsp_valid.
- Throughput is 1 result/cycle with rsp_ready held high.
- Fairness: a continuously-valid requester is granted within N_REQ accepts.
- A requester that drops valid before being granted loses nothing. There is no request memory.
- ptr wraps from N_REQ-1 to 0.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req_valid=4'hF and rsp_ready=1 -> req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, ops_count=0 throughout.
2. Single request: requester 2 with a=8'hA5, b=8'h0F, rsp_ready=1 -> req_ready=4'b0100 in that cycle. Next cycle rsp_valid=1, rsp_data=8'hAA, rsp_id=2, ops_count=1.
3. Round robin: req_valid=4'hF held for 5 cycles with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles. ops_count=5 and rsp_valid=1 every cycle after the first.
4. Backpressure: with rsp_valid=1, hold rsp_ready=0 for 3 cycles while req_valid=4'b0011 -> req_ready=0, rsp_data and rsp_id unchanged. In the cycle rsp_ready=1, a grant is issued and the slot is refilled on the next edge.
5. Truth table: WIDTH=1, N_REQ=2 instance, requester 0 sends (0,0),(0,1),(1,0),(1,1) -> rsp_data 0,1,1,0 with rsp_id=0. Write each result with $time to a log file.
6. Reset mid-operation: rsp_valid=1, ptr=2, then rst_n=0 for one edge -> rsp_valid=0. Then release with req_valid=4'b1001 -> first grant goes to requester 0, second to requester 3.

Source files
------------

// File: rtl/xor_rr_scheduler.sv
// rtl/xor_rr_scheduler.sv - round-robin arbiter that shares one registered XOR unit between N_REQ requesters
module xor_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [15:0]            ops_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              slot_free;
  logic              accept;
  int                idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Scan ptr, ptr+1, ... wrapping; first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_free = (state_q == EMPTY) || rsp_ready;
    req_ready = '0;
    if (rst_n && slot_free && found) req_ready[winner] = 1'b1;
    if (slot_free) state_d = found ? FULL : EMPTY;
  end

  assign accept    = |req_ready;
  assign rsp_valid = (state_q == FULL);
  assign busy      = rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      ops_count <= '0;
    end else if (accept) begin
      rsp_data <= req_a[int'(winner)*WIDTH +: WIDTH] ^ req_b[int'(winner)*WIDTH +: WIDTH];
      rsp_id   <= winner;
      ptr      <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
      if (ops_count != 16'hFFFF) ops_count <= ops_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// tb/tb_xor_rr_scheduler.sv - directed scoreboard bench for xor_rr_scheduler
module tb_xor_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, busy;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] ops_count;

  logic [1:0]  v1, a1, b1, r1_ready;
  logic        o1_valid, o1_data, o1_id, o1_ready, busy1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  xor_rr_scheduler #(.WIDTH(8), .N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .ops_count(ops_count)
  );

  xor_rr_scheduler #(.WIDTH(1), .N_REQ(2), .ID_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
    .req_ready(r1_ready), .rsp_valid(o1_valid), .rsp_data(o1_data), .rsp_id(o1_id),
    .rsp_ready(o1_ready), .busy(busy1), .ops_count(cnt1)
  );

  typedef struct { logic [7:0] data; logic [1:0] id; } exp_t;
  exp_t q[$];

  int          checks = 0;
  int          errors = 0;
  bit          m_full;
  int          m_ptr;
  logic [15:0] m_count;
  int          last_grant;
  int          grants[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One clock: check combinational grant and slot contents, then advance the model.
  task automatic tick();
    int         w;
    logic [3:0] exp_ready;
    bit         free;
    exp_t       e;
    #1;
    free      = !m_full || rsp_ready;
    w         = -1;
    exp_ready = '0;
    if (rst_n && free) w = pick(req_valid, m_ptr);
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("busy", 32'(busy), 32'(m_full));
    if (rst_n && m_full) begin
      if (q.size() == 0) chk("sb_size", 32'(q.size()), 32'd1);
      else begin
        chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        if (rsp_ready) void'(q.pop_front());
      end
    end
    last_grant = w;
    if (w >= 0) begin
      e.data = req_a[w*8 +: 8] ^ req_b[w*8 +: 8];
      e.id   = w[1:0];
      q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_full = 0; m_ptr = 0; m_count = '0; q.delete();
    end else if (free) begin
      m_full = (w >= 0);
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end
    #1;
    chk("ops_count", 32'(ops_count), 32'(m_count));
  endtask

  logic te [4];
  logic ta [4];
  logic tb [4];

  initial begin
    ta = '{1'b0, 1'b0, 1'b1, 1'b1};
    tb = '{1'b0, 1'b1, 1'b0, 1'b1};
    te = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
    v1 = 2'b00; a1 = 2'b00; b1 = 2'b00; o1_ready = 1'b1;
    m_full = 0; m_ptr = 0; m_count = '0; last_grant = -1;
    @(posedge clk); #1;

    // 1: reset held with all requesters valid
    tick(); tick();
    chk("rst_data", 32'(rsp_data), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);

    // 2: single request from requester 2
    rst_n = 1'b1; req_valid = 4'b0100;
    req_a = 32'h00A5_0000; req_b = 32'h000F_0000;
    tick();
    chk("t2_grant", 32'(last_grant), 32'd2);
    chk("t2_data", 32'(rsp_data), 32'hAA);
    chk("t2_id", 32'(rsp_id), 32'd2);
    chk("t2_count", 32'(ops_count), 32'd1);
    req_valid = 4'b0000;
    tick();

    // 3: all valid, round-robin 0,1,2,3,0
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      req_a = $urandom; req_b = $urandom;
      tick();
      grants[i] = last_grant;
      chk("t3_valid", 32'(rsp_valid), 32'd1);
    end
    chk("t3_g0", 32'(grants[0]), 32'd0);
    chk("t3_g1", 32'(grants[1]), 32'd1);
    chk("t3_g2", 32'(grants[2]), 32'd2);
    chk("t3_g3", 32'(grants[3]), 32'd3);
    chk("t3_g4", 32'(grants[4]), 32'd0);
    chk("t3_count", 32'(ops_count), 32'd5);

    // 4: backpressure for 3 cycles, then drain and refill together
    req_valid = 4'b0011; rsp_ready = 1'b0;
    req_a = $urandom; req_b = $urandom;
    for (int i = 0; i < 3; i++) tick();
    rsp_ready = 1'b1;
    tick();
    chk("t4_grant", 32'(last_grant), 32'd1);
    chk("t4_valid", 32'(rsp_valid), 32'd1);
    req_valid = 4'b0000;
    tick();

    // 5: one-bit, two-requester truth table
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v1 = 2'b01; a1 = {1'b0, ta[k]}; b1 = {1'b0, tb[k]};
      #1;
      chk("t5_ready", 32'(r1_ready), 32'd1);
      @(posedge clk); #1;
      chk("t5_valid", 32'(o1_valid), 32'd1);
      chk("t5_data", 32'(o1_data), 32'(te[k]));
      chk("t5_id", 32'(o1_id), 32'd0);
      $display("t5 time=%0t a=%0d b=%0d rsp_data=%0d", $time, a1[0], b1[0], o1_data);
      v1 = 2'b00;
    end
    chk("t5_count", 32'(cnt1), 32'd4);

    // 6: reset with a held result and ptr=2, then restart
    req_valid = 4'b0010; rsp_ready = 1'b0;
    req_a = $urandom; req_b = $urandom;
    tick();
    req_valid = 4'b0000; rst_n = 1'b0;
    tick();
    chk("t6_flush", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1; req_valid = 4'b1001; rsp_ready = 1'b1;
    tick();
    chk("t6_first", 32'(last_grant), 32'd0);
    tick();
    chk("t6_second", 32'(last_grant), 32'd3);
    req_valid = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
